// File: rtl/mem_ring_arbiter_pkg.sv
// Shared types and helpers for the memory-bus ring arbiter.
// Channel ids are sized for the largest supported channel count so one type serves every build.
package mem_ring_arbiter_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_RD_LATENCY = 2;
    localparam int MAX_REQ        = 8;
    localparam int CH_ID_W        = $clog2(MAX_REQ);

    typedef logic [CH_ID_W-1:0] ch_id_t;
    typedef logic [MAX_REQ-1:0] ch_vec_t;

    function automatic ch_id_t onehot_to_id(input ch_vec_t oh);
        ch_id_t id;
        id = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                id = id | ch_id_t'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/rr_grant_select.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping modulo N.
module rr_grant_select
    import mem_ring_arbiter_pkg::*;
#(
    parameter int N = DEF_NUM_REQ
) (
    input  logic [N-1:0] req,
    input  ch_id_t       ptr,
    output logic [N-1:0] gnt,
    output ch_id_t       gnt_id,
    output logic         gnt_vld
);

    ch_vec_t req_pad;
    ch_vec_t gnt_pad;
    ch_id_t  idx;

    always_comb begin
        req_pad        = '0;
        req_pad[N-1:0] = req;
        gnt_pad        = '0;
        gnt_vld        = 1'b0;
        idx            = '0;
        for (int k = 0; k < N; k++) begin
            idx = ch_id_t'((int'(ptr) + k) % N);
            if (!gnt_vld && req_pad[idx]) begin
                gnt_vld      = 1'b1;
                gnt_pad[idx] = 1'b1;
            end
        end
        gnt_id = onehot_to_id(gnt_pad);
        gnt    = gnt_pad[N-1:0];
    end

endmodule

// File: rtl/mem_ring_arbiter.sv
// Round-robin arbiter sharing one memory bus among ring-buffer channels,
// with bounded burst locking and an in-order read-return tag pipeline.
module mem_ring_arbiter
    import mem_ring_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int MAX_BURST  = 8
) (
    input  logic                      clk,
    input  logic                      nRst,
    input  logic [NUM_REQ-1:0]        req_rd,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_rd,
    output logic                      mem_wr,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int BC_W = $clog2(MAX_BURST + 1);

    logic [NUM_REQ-1:0] req_any;
    ch_vec_t            rd_pad, wr_pad, lock_pad, any_pad;
    logic [NUM_REQ-1:0] rr_gnt, own_oh, gnt_oh;
    ch_id_t             rr_id, gnt_id;
    logic               rr_vld, owner_hit, gnt_vld;

    ch_id_t             rr_ptr_q, rr_ptr_d;
    ch_id_t             owner_q, owner_d;
    logic               owner_vld_q, owner_vld_d;
    logic [BC_W-1:0]    burst_cnt_q, burst_cnt_d, next_cnt;

    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    ch_id_t             mem_id_q, mem_id_d;

    logic               pipe_vld_q [RD_LATENCY];
    logic               pipe_vld_d [RD_LATENCY];
    ch_id_t             pipe_id_q  [RD_LATENCY];
    ch_id_t             pipe_id_d  [RD_LATENCY];
    logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;

    assign req_any = req_rd | req_wr;

    rr_grant_select #(.N(NUM_REQ)) u_rr_grant_select (
        .req     (req_any),
        .ptr     (rr_ptr_q),
        .gnt     (rr_gnt),
        .gnt_id  (rr_id),
        .gnt_vld (rr_vld)
    );

    always_comb begin
        rd_pad                     = '0;
        wr_pad                     = '0;
        lock_pad                   = '0;
        any_pad                    = '0;
        rd_pad[NUM_REQ-1:0]        = req_rd;
        wr_pad[NUM_REQ-1:0]        = req_wr;
        lock_pad[NUM_REQ-1:0]      = req_lock;
        any_pad[NUM_REQ-1:0]       = req_any;
        for (int i = 0; i < NUM_REQ; i++) begin
            own_oh[i] = (owner_q == ch_id_t'(i));
        end
        // A locked owner keeps the bus only while it still asks and has burst budget left.
        owner_hit = owner_vld_q && any_pad[owner_q] && (burst_cnt_q < BC_W'(MAX_BURST));
        gnt_vld   = owner_hit || rr_vld;
        gnt_id    = owner_hit ? owner_q : rr_id;
        gnt_oh    = owner_hit ? own_oh : rr_gnt;
    end

    assign req_ack = gnt_oh & {NUM_REQ{nRst}};

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        burst_cnt_d = burst_cnt_q;
        next_cnt    = '0;
        if (gnt_vld) begin
            rr_ptr_d = (gnt_id == ch_id_t'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            if (lock_pad[gnt_id]) begin
                next_cnt = (owner_vld_q && (owner_q == gnt_id)) ? burst_cnt_q + 1'b1 : BC_W'(1);
                if (next_cnt >= BC_W'(MAX_BURST)) begin
                    owner_vld_d = 1'b0;
                    burst_cnt_d = '0;
                end else begin
                    owner_vld_d = 1'b1;
                    owner_d     = gnt_id;
                    burst_cnt_d = next_cnt;
                end
            end else begin
                owner_vld_d = 1'b0;
                burst_cnt_d = '0;
            end
        end else if (owner_vld_q && !any_pad[owner_q]) begin
            owner_vld_d = 1'b0;
            burst_cnt_d = '0;
        end
    end

    always_comb begin
        // A simultaneous read+write request is treated as a write only.
        mem_rd_d    = gnt_vld && rd_pad[gnt_id] && !wr_pad[gnt_id];
        mem_wr_d    = gnt_vld && wr_pad[gnt_id];
        mem_id_d    = gnt_vld ? gnt_id : mem_id_q;
        mem_addr_d  = gnt_vld ? req_addr[int'(gnt_id)*ADDR_W +: ADDR_W] : mem_addr_q;
        mem_wdata_d = gnt_vld ? req_wdata[int'(gnt_id)*DATA_W +: DATA_W] : mem_wdata_q;
    end

    always_comb begin
        pipe_vld_d[0] = mem_rd_q;
        pipe_id_d[0]  = mem_id_q;
        for (int k = 1; k < RD_LATENCY; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            pipe_id_d[k]  = pipe_id_q[k-1];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_valid_d[i] = pipe_vld_q[RD_LATENCY-1] && (pipe_id_q[RD_LATENCY-1] == ch_id_t'(i));
        end
        rd_data_d = pipe_vld_q[RD_LATENCY-1] ? mem_rdata : rd_data_q;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            burst_cnt_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_id_q    <= '0;
            rd_valid_q  <= '0;
            rd_data_q   <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_vld_q[k] <= 1'b0;
                pipe_id_q[k]  <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            burst_cnt_q <= burst_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_id_q    <= mem_id_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_vld_q[k] <= pipe_vld_d[k];
                pipe_id_q[k]  <= pipe_id_d[k];
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_mem_ring_arbiter.sv
// Bench for mem_ring_arbiter: behavioural memory, scoreboard of expected read returns and bus strobes.
module tb_mem_ring_arbiter;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RL = 2;
    localparam int MB = 8;

    logic              clk;
    logic              nRst;
    logic [NR-1:0]     req_rd, req_wr, req_lock;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ack, rd_valid;
    logic [DW-1:0]     rd_data, mem_wdata, mem_rdata;
    logic [AW-1:0]     mem_addr;
    logic              mem_rd, mem_wr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          ch;
        logic [15:0] data;
        int          cyc;
    } sb_t;
    sb_t sb_q[$];

    logic [DW-1:0] mem    [1024];
    logic [DW-1:0] shadow [1024];
    logic [DW-1:0] rd_pipe [RL];

    mem_ring_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RL), .MAX_BURST(MB)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0085) return 16'hAB45;
        return a ^ 16'hA5A5;
    endfunction

    // Memory device: data for a read strobed in cycle c is presented during cycle c+RL.
    assign mem_rdata = rd_pipe[RL-1];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_val(16'(i));
        for (int k = 0; k < RL; k++) rd_pipe[k] <= '0;
        forever begin
            @(posedge clk);
            rd_pipe[0] <= mem_rd ? mem[mem_addr[9:0]] : '0;
            for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
            if (mem_wr) mem[mem_addr[9:0]] = mem_wdata;
        end
    end

    // Monitor / scoreboard
    initial begin
        logic          exp_rd, exp_wr;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        int            g;
        logic [AW-1:0] a;
        sb_t           e;
        exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0;
        for (int i = 0; i < 1024; i++) shadow[i] = init_val(16'(i));
        forever begin
            @(negedge clk);
            if (!nRst) begin
                sb_q.delete();
                exp_rd = 1'b0;
                exp_wr = 1'b0;
            end else begin
                n_checks++;
                if (mem_rd !== exp_rd || mem_wr !== exp_wr) begin
                    n_fail++;
                    $display("FAIL strobe cyc %0d: got rd=%b wr=%b expected rd=%b wr=%b", cyc, mem_rd, mem_wr, exp_rd, exp_wr);
                end
                if (exp_rd || exp_wr) begin
                    n_checks++;
                    if (mem_addr !== exp_addr) begin
                        n_fail++;
                        $display("FAIL mem_addr cyc %0d: got %h expected %h", cyc, mem_addr, exp_addr);
                    end
                end
                if (exp_wr) begin
                    n_checks++;
                    if (mem_wdata !== exp_wdata) begin
                        n_fail++;
                        $display("FAIL mem_wdata cyc %0d: got %h expected %h", cyc, mem_wdata, exp_wdata);
                    end
                end
                if (rd_valid !== '0) begin
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_rd_valid cyc %0d: got %b expected 0000", cyc, rd_valid);
                    end else begin
                        e = sb_q.pop_front();
                        if (rd_valid !== NR'(1 << e.ch) || rd_data !== e.data || cyc != e.cyc) begin
                            n_fail++;
                            $display("FAIL rd_return cyc %0d: got vld=%b data=%h expected vld=%b data=%h at cyc %0d",
                                     cyc, rd_valid, rd_data, NR'(1 << e.ch), e.data, e.cyc);
                        end
                    end
                end
                n_checks++;
                if ($countones(req_ack) > 1) begin
                    n_fail++;
                    $display("FAIL ack_onehot cyc %0d: got %b expected at most one bit", cyc, req_ack);
                end
                exp_rd = 1'b0;
                exp_wr = 1'b0;
                g = -1;
                for (int i = 0; i < NR; i++) if (req_ack[i]) g = i;
                if (g >= 0) begin
                    a        = req_addr[g*AW +: AW];
                    exp_addr = a;
                    if (req_wr[g]) begin
                        exp_wr          = 1'b1;
                        exp_wdata       = req_wdata[g*DW +: DW];
                        shadow[a[9:0]]  = exp_wdata;
                    end else if (req_rd[g]) begin
                        exp_rd = 1'b1;
                        sb_q.push_back('{ch: g, data: shadow[a[9:0]], cyc: cyc + 2 + RL});
                    end
                end
            end
        end
    end

    task automatic set_ch(input int ch, input logic rd, input logic wr, input logic lock,
                          input logic [15:0] addr, input logic [15:0] data);
        req_rd[ch]              = rd;
        req_wr[ch]              = wr;
        req_lock[ch]            = lock;
        req_addr[ch*AW +: AW]   = addr;
        req_wdata[ch*DW +: DW]  = data;
    endtask

    task automatic clear_all();
        req_rd   = '0;
        req_wr   = '0;
        req_lock = '0;
    endtask

    task automatic wait_ack(input int ch, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ack[ch]) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        nRst = 1'b1;
        clear_all();
        req_addr = '0;
        req_wdata = '0;
        #1 nRst = 1'b0;
        set_ch(0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        #1;
        n_checks++;
        if ({mem_rd, mem_wr, rd_valid, req_ack} !== '0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 0", {mem_rd, mem_wr, rd_valid, req_ack});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, rd_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h expected 0", {mem_addr, mem_wdata, rd_data});
        end
        clear_all();
        @(posedge clk); #1 nRst = 1'b1;
        @(posedge clk); #1 set_ch(1, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
        wait_ack(1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL reset_rd_ack: got no ack expected ack on ch1"); end
        @(posedge clk); #1 clear_all();
        @(posedge clk); #1 nRst = 1'b0;
        #1;
        n_checks++;
        if ({mem_rd, mem_wr, rd_valid, req_ack} !== '0) begin
            n_fail++;
            $display("FAIL midread_reset: got %b expected 0", {mem_rd, mem_wr, rd_valid, req_ack});
        end
        repeat (2) @(posedge clk);
        #1 nRst = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            n_checks++;
            if (rd_valid !== '0) begin
                n_fail++;
                $display("FAIL aborted_read: got rd_valid %b expected 0000", rd_valid);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] e;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) set_ch(i, 1'b0, 1'b1, 1'b0, 16'(i * 16'h40), 16'(16'h1000 + i));
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            e = NR'(1 << (n % NR));
            n_checks++;
            if (req_ack !== e) begin
                n_fail++;
                $display("FAIL rr_ack step %0d: got %b expected %b", n, req_ack, e);
            end
        end
        @(posedge clk); #1 clear_all();
    endtask

    task automatic test_read_latency();
        bit ok;
        @(posedge clk); #1 set_ch(2, 1'b1, 1'b0, 1'b0, 16'h0085, 16'h0000);
        wait_ack(2, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL lat_ack: got no ack expected ack on ch2"); end
        @(posedge clk); #1 clear_all();
        @(negedge clk);
        n_checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0085) begin
            n_fail++;
            $display("FAIL lat_strobe: got rd=%b addr=%h expected rd=1 addr=0085", mem_rd, mem_addr);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (rd_valid !== '0) begin
            n_fail++;
            $display("FAIL lat_early: got rd_valid %b expected 0000 at t+3", rd_valid);
        end
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 4'b0100 || rd_data !== 16'hAB45) begin
            n_fail++;
            $display("FAIL lat_return: got vld=%b data=%h expected vld=0100 data=ab45", rd_valid, rd_data);
        end
    endtask

    task automatic test_burst_lock();
        int exp_seq[11];
        int idx, n0;
        bit ch3_done;
        exp_seq = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0};
        idx = 0; n0 = 0; ch3_done = 1'b0;
        @(posedge clk); #1 set_ch(0, 1'b0, 1'b1, 1'b1, 16'h0200, 16'h2000);
        for (int n = 0; n < 40 && idx < 11; n++) begin
            @(negedge clk);
            n_checks++;
            if (req_ack !== NR'(1 << exp_seq[idx])) begin
                n_fail++;
                $display("FAIL burst_ack step %0d: got %b expected %b", idx, req_ack, NR'(1 << exp_seq[idx]));
            end
            if (req_ack[0]) n0++;
            if (req_ack[3]) ch3_done = 1'b1;
            idx++;
            @(posedge clk); #1;
            if (idx == 1) set_ch(3, 1'b0, 1'b1, 1'b0, 16'h0300, 16'h3333);
            if (ch3_done) set_ch(3, 1'b0, 1'b0, 1'b0, 16'h0300, 16'h3333);
            if (n0 >= 10) set_ch(0, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h2000);
            else set_ch(0, 1'b0, 1'b1, 1'b1, 16'(16'h0200 + n0), 16'(16'h2000 + n0));
        end
        n_checks++;
        if (idx != 11) begin
            n_fail++;
            $display("FAIL burst_timeout: got %0d steps expected 11", idx);
        end
        clear_all();
    endtask

    task automatic test_lock_idle();
        logic [NR-1:0] st_wr [7];
        logic [NR-1:0] st_lk [7];
        logic [NR-1:0] st_ex [7];
        st_wr = '{4'b0010, 4'b0100, 4'b0010, 4'b0000, 4'b1010, 4'b0010, 4'b0010};
        st_lk = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
        st_ex = '{4'b0010, 4'b0100, 4'b0010, 4'b0000, 4'b1000, 4'b0010, 4'b0010};
        for (int s = 0; s < 7; s++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++)
                set_ch(i, 1'b0, st_wr[s][i], st_lk[s][i], 16'(16'h0100 + i * 16), 16'(16'h4000 + s * 16 + i));
            @(negedge clk);
            n_checks++;
            if (req_ack !== st_ex[s]) begin
                n_fail++;
                $display("FAIL lock_idle step %0d: got %b expected %b", s, req_ack, st_ex[s]);
            end
        end
        @(posedge clk); #1 clear_all();
    endtask

    task automatic test_rw_order();
        int got;
        logic [NR-1:0] exp_ack [3];
        exp_ack = '{4'b0001, 4'b0010, 4'b0001};
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            clear_all();
            if (s == 1) set_ch(1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h5BCF);
            else        set_ch(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
            @(negedge clk);
            n_checks++;
            if (req_ack !== exp_ack[s]) begin
                n_fail++;
                $display("FAIL order_ack step %0d: got %b expected %b", s, req_ack, exp_ack[s]);
            end
        end
        @(posedge clk); #1 clear_all();
        got = 0;
        for (int n = 0; n < 10 && got < 2; n++) begin
            @(negedge clk);
            if (rd_valid !== '0) begin
                n_checks++;
                if (rd_valid !== 4'b0001 || rd_data !== ((got == 0) ? init_val(16'h0010) : 16'h5BCF)) begin
                    n_fail++;
                    $display("FAIL order_return %0d: got vld=%b data=%h expected vld=0001 data=%h",
                             got, rd_valid, rd_data, (got == 0) ? init_val(16'h0010) : 16'h5BCF);
                end
                got++;
            end
        end
        n_checks++;
        if (got != 2) begin n_fail++; $display("FAIL order_count: got %0d expected 2", got); end
    endtask

    task automatic test_conflict();
        bit ok;
        int got;
        @(posedge clk); #1 set_ch(3, 1'b1, 1'b1, 1'b0, 16'h0030, 16'h1234);
        wait_ack(3, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL conflict_ack: got no ack expected ack on ch3"); end
        @(posedge clk); #1 set_ch(3, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000);
        @(negedge clk);
        n_checks++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_strobe: got rd=%b wr=%b expected rd=0 wr=1", mem_rd, mem_wr);
        end
        @(posedge clk); #1 clear_all();
        got = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (rd_valid !== '0) begin
                got++;
                n_checks++;
                if (rd_valid !== 4'b1000 || rd_data !== 16'h1234) begin
                    n_fail++;
                    $display("FAIL conflict_return: got vld=%b data=%h expected vld=1000 data=1234", rd_valid, rd_data);
                end
            end
        end
        n_checks++;
        if (got != 1) begin n_fail++; $display("FAIL conflict_count: got %0d returns expected 1", got); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_read_latency();
        test_burst_lock();
        test_lock_idle();
        test_rw_order();
        test_conflict();
        repeat (10) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending reads expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ring_arbiter.md
Name: mem_ring_arbiter

Overview:
- Shares the single external memory bus among the ring-buffer channels (two rings per mil/spi link, four in the double-link IP).
- Arbitration is round-robin between channels.
- A channel may lock the bus for a bounded burst, so one packet's words land back-to-back.
- Sits between the ring-buffer controllers and the memory-bus master port. Performs no address translation: each ring supplies absolute addresses inside its own START..END window.

Parameters:
- NUM_REQ, 4, number of requesting channels (2..8)
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- RD_LATENCY, 2, cycles from mem_rd strobe to mem_rdata valid (1..4)
- MAX_BURST, 8, max consecutive grants to a locked channel before a forced rotate

Ports:
- clk  in  1  system clock; all logic on rising edge
- nRst  in  1  asynchronous active-low reset
- req_rd  in  NUM_REQ  per-channel read request (valid)
- req_wr  in  NUM_REQ  per-channel write request (valid)
- req_lock  in  NUM_REQ  channel wants to keep the grant after this access
- req_addr  in  NUM_REQ*ADDR_W  packed per-channel address; channel i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed per-channel write data
- req_ack  out  NUM_REQ  one-hot, combinational; access accepted this cycle
- rd_valid  out  NUM_REQ  one-hot, registered; rd_data belongs to this channel
- rd_data  out  DATA_W  read data broadcast to all channels
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rd  out  1  memory read strobe, registered, one cycle per access
- mem_wr  out  1  memory write strobe, registered
- mem_rdata  in  DATA_W  memory read data, valid RD_LATENCY cycles after mem_rd

Behaviour:
- Reset (async, nRst=0):
  - mem_rd, mem_wr, rd_valid, req_ack = 0; mem_addr, mem_wdata, rd_data = 0.
  - Round-robin pointer rr_ptr = 0; owner = none; burst_cnt = 0; read-tracking pipeline cleared.
  - Reset mid-operation drops in-flight reads silently; no rd_valid is produced for them.
- Handshake:
  - Channel i requests when req_rd[i] or req_wr[i] is high.
  - Transfer occurs in cycle t when req_ack[i]=1. The channel holds addr, data and request stable until ack, and may present the next access at t+1.
- Conflicting request: req_rd[i] and req_wr[i] both high is illegal. The write is performed and no rd_valid is generated.
- Arbitration (combinational each cycle):
  - If owner is valid, the owner's request is high, and burst_cnt < MAX_BURST: grant owner.
  - Otherwise grant the first requesting channel searching from rr_ptr upward, modulo NUM_REQ.
  - No requests: no grant, no strobe.
- On grant to channel g at cycle t:
  - req_ack[g]=1 at t.
  - At t+1: mem_addr, mem_wdata, mem_rd/mem_wr reflect g's access.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Lock handling at the same edge:
  - If req_lock[g] and g was already owner: burst_cnt increments. If g was not owner: owner <= g and burst_cnt <= 1.
  - If req_lock[g]=0: owner released, burst_cnt <= 0.
  - When burst_cnt reaches MAX_BURST: owner released and arbitration reverts to round-robin from rr_ptr. g may win again only if no other channel requests.
- Owner idle: if the owner drops its request for a cycle while locked, ownership is released that cycle.
- Throughput: one access per cycle, no bubbles between back-to-back grants to different channels.
- Read return:
  - A shift pipeline of depth RD_LATENCY carries {valid, channel id}.
  - For a read issued at t+1, rd_data is registered from mem_rdata, with rd_valid[g]=1 for one cycle, at t+2+RD_LATENCY.
  - Read returns are strictly in issue order. Writes never produce rd_valid.
- Simultaneous events: a read return and a new grant in the same cycle are independent and both occur.

Decomposition:
- A shared package holds a typedef for channel id (logic [$clog2(NUM_REQ)-1:0]) and the one-hot/ID conversion function.
- The package also holds constants for the default ring count (4) and RD_LATENCY.
- One natural sub-module: rr_grant_select, a combinational round-robin priority picker (request vector + pointer -> one-hot grant + id), reusable by other arbiters.
- Lock/burst state, output registers and the read pipeline stay in the top.

Test Plan:
- Reset: nRst low mid-read of ch1 → all strobes, acks and rd_valid 0; no rd_valid for the aborted read after release.
- Round-robin: all 4 channels assert req_wr continuously, no lock → acks cycle 0,1,2,3,0... one per cycle; mem_addr follows each channel's address (0x00, 0x40, 0x80, 0xC0).
- Read latency: ch2 reads 0x85 holding 0xAB45, RD_LATENCY=2 → ack at t, mem_rd at t+1, rd_valid=4'b0100 with rd_data=0xAB45 at t+4.
- Burst lock: ch0 requests 10 writes with req_lock=1 while ch3 requests → ch0 gets 8 consecutive acks, then ch3 acked, then ch0 resumes.
- Lock release by idle: ch1 locks, drops its request for one cycle while ch2 requests → ch2 acked in that cycle; ch1 ownership cleared.
- Read/write ordering: ch0 reads 0x10, ch1 writes 0x10=0x5BCF, ch0 reads 0x10 → first rd_valid ch0 returns the old value, second returns 0x5BCF, in issue order.
